tile_controller: RTL and testbench

TILE_CONTROLLER -- requirements
Module: tile_controller

---
 rtl/tile_controller.sv | 208 ++++++++++++++++++++
 tb/tb_tile_controller.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_controller.sv
// Tile sequencer for a systolic array: streams operands and weights into L0 and the input FIFO,
// runs the array in weight-stationary or output-stationary mode, and writes psums back tile by tile.
module tile_controller #(
    parameter int ROW    = 8,
    parameter int COL    = 8,
    parameter int LEN    = 8,
    parameter int ADDR_W = 11,
    parameter int TILE_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic              relu,
    input  logic [TILE_W-1:0] num_tiles,
    input  logic [ADDR_W-1:0] in_base,
    input  logic [ADDR_W-1:0] out_base,
    input  logic              l0_full,
    input  logic              ififo_full,
    input  logic              ofifo_valid,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              l0_wr,
    output logic              l0_rd,
    output logic              ififo_wr,
    output logic              ififo_rd,
    output logic              ofifo_rd,
    output logic [1:0]        inst_w,
    output logic              sfp_acc_en,
    output logic              sfp_relu_en,
    output logic [ADDR_W-1:0] psum_addr,
    output logic              psum_wr,
    output logic [TILE_W-1:0] tile_idx,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(LEN + ROW + COL + 1);

    localparam logic [CNT_W-1:0] ROW_M1  = CNT_W'(ROW - 1);
    localparam logic [CNT_W-1:0] LEN_M1  = CNT_W'(LEN - 1);
    localparam logic [CNT_W-1:0] FEED_M1 = CNT_W'(ROW + COL - 1);
    localparam logic [CNT_W-1:0] EXEC_M1 = CNT_W'(LEN + ROW + COL - 1);

    typedef enum logic [3:0] {
        IDLE,
        WS_LOAD_W,
        WS_FEED_W,
        WS_LOAD_X,
        WS_EXEC,
        OS_LOAD_X,
        OS_LOAD_W,
        OS_EXEC,
        WRITEBACK,
        NEXT,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  sram_q, sram_d;
    logic [ADDR_W-1:0]  psum_q, psum_d;
    logic [TILE_W-1:0]  tile_q, tile_d;
    logic [TILE_W-1:0]  last_q, last_d;
    logic               mode_q, mode_d;
    logic               relu_q, relu_d;

    assign sram_addr = sram_q;
    assign psum_addr = psum_q;
    assign tile_idx  = tile_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sram_d      = sram_q;
        psum_d      = psum_q;
        tile_d      = tile_q;
        last_d      = last_q;
        mode_d      = mode_q;
        relu_d      = relu_q;
        l0_wr       = 1'b0;
        l0_rd       = 1'b0;
        ififo_wr    = 1'b0;
        ififo_rd    = 1'b0;
        ofifo_rd    = 1'b0;
        inst_w      = 2'b00;
        sfp_acc_en  = 1'b0;
        sfp_relu_en = 1'b0;
        psum_wr     = 1'b0;
        busy        = (state_q != IDLE);
        done        = (state_q == DONE);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sram_d  = in_base;
                    psum_d  = out_base;
                    tile_d  = '0;
                    cnt_d   = '0;
                    mode_d  = mode;
                    relu_d  = relu;
                    // Zero tiles runs as a single tile.
                    last_d  = (num_tiles == '0) ? '0 : num_tiles - 1'b1;
                    state_d = mode ? OS_LOAD_X : WS_LOAD_W;
                end
            end
            WS_LOAD_W, WS_LOAD_X, OS_LOAD_X: begin
                l0_wr = !l0_full;
                if (l0_wr) begin
                    sram_d = sram_q + 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (state_q == WS_LOAD_W && cnt_q == ROW_M1) begin
                        cnt_d   = '0;
                        state_d = WS_FEED_W;
                    end else if (state_q == WS_LOAD_X && cnt_q == LEN_M1) begin
                        cnt_d   = '0;
                        state_d = WS_EXEC;
                    end else if (state_q == OS_LOAD_X && cnt_q == LEN_M1) begin
                        cnt_d   = '0;
                        state_d = OS_LOAD_W;
                    end
                end
            end
            OS_LOAD_W: begin
                ififo_wr = !ififo_full;
                if (ififo_wr) begin
                    sram_d = sram_q + 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == LEN_M1) begin
                        cnt_d   = '0;
                        state_d = OS_EXEC;
                    end
                end
            end
            WS_FEED_W: begin
                inst_w = 2'b01;
                l0_rd  = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == FEED_M1) begin
                    cnt_d   = '0;
                    state_d = WS_LOAD_X;
                end
            end
            WS_EXEC, OS_EXEC: begin
                inst_w   = 2'b10;
                l0_rd    = 1'b1;
                ififo_rd = (state_q == OS_EXEC);
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == EXEC_M1) begin
                    cnt_d   = '0;
                    state_d = WRITEBACK;
                end
            end
            WRITEBACK: begin
                ofifo_rd    = ofifo_valid;
                psum_wr     = ofifo_valid;
                sfp_acc_en  = (tile_q != '0);
                sfp_relu_en = relu_q && (tile_q == last_q);
                if (ofifo_valid) begin
                    psum_d = psum_q + 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == (mode_q ? ROW_M1 : LEN_M1)) begin
                        cnt_d   = '0;
                        state_d = NEXT;
                    end
                end
            end
            NEXT: begin
                if (tile_q == last_q) begin
                    state_d = DONE;
                end else begin
                    tile_d  = tile_q + 1'b1;
                    psum_d  = out_base;
                    cnt_d   = '0;
                    state_d = mode_q ? OS_LOAD_X : WS_LOAD_W;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sram_q  <= '0;
            psum_q  <= '0;
            tile_q  <= '0;
            last_q  <= '0;
            mode_q  <= 1'b0;
            relu_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sram_q  <= sram_d;
            psum_q  <= psum_d;
            tile_q  <= tile_d;
            last_q  <= last_d;
            mode_q  <= mode_d;
            relu_q  <= relu_d;
        end
    end

endmodule

// File: tb/tb_tile_controller.sv
// Randomized bench for tile_controller against a phase-queue reference model.
// Each run is described as a list of (phase, length) segments consumed cycle by cycle.
module tb_tile_controller;

    localparam int ROW = 8;
    localparam int COL = 8;
    localparam int LEN = 8;
    localparam int AW  = 11;
    localparam int TW  = 4;

    logic          clk = 1'b0;
    logic          reset, start, mode, relu;
    logic [TW-1:0] num_tiles;
    logic [AW-1:0] in_base, out_base;
    logic          l0_full, ififo_full, ofifo_valid;
    logic [AW-1:0] sram_addr, psum_addr;
    logic          l0_wr, l0_rd, ififo_wr, ififo_rd, ofifo_rd;
    logic [1:0]    inst_w;
    logic          sfp_acc_en, sfp_relu_en, psum_wr, busy, done;
    logic [TW-1:0] tile_idx;

    always #5 clk = ~clk;

    tile_controller #(
        .ROW(ROW), .COL(COL), .LEN(LEN), .ADDR_W(AW), .TILE_W(TW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .relu(relu), .num_tiles(num_tiles), .in_base(in_base),
        .out_base(out_base), .l0_full(l0_full), .ififo_full(ififo_full),
        .ofifo_valid(ofifo_valid), .sram_addr(sram_addr), .l0_wr(l0_wr),
        .l0_rd(l0_rd), .ififo_wr(ififo_wr), .ififo_rd(ififo_rd),
        .ofifo_rd(ofifo_rd), .inst_w(inst_w), .sfp_acc_en(sfp_acc_en),
        .sfp_relu_en(sfp_relu_en), .psum_addr(psum_addr), .psum_wr(psum_wr),
        .tile_idx(tile_idx), .busy(busy), .done(done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef enum {K_LDL0, K_LDFF, K_FEED, K_EXW, K_EXO, K_WB, K_NEXT, K_DONE} kind_e;
    typedef struct {
        kind_e k;
        int    n;
    } seg_t;

    seg_t          q[$];
    bit            m_act;
    bit            m_mode, m_relu;
    logic [AW-1:0] m_sram, m_psum;
    logic [TW-1:0] m_tile, m_last;
    bit            stall_en;

    function automatic void push_tile();
        if (!m_mode) begin
            q.push_back('{K_LDL0, ROW});
            q.push_back('{K_FEED, ROW + COL});
            q.push_back('{K_LDL0, LEN});
            q.push_back('{K_EXW, LEN + ROW + COL});
            q.push_back('{K_WB, LEN});
        end else begin
            q.push_back('{K_LDL0, LEN});
            q.push_back('{K_LDFF, LEN});
            q.push_back('{K_EXO, LEN + ROW + COL});
            q.push_back('{K_WB, ROW});
        end
        q.push_back('{K_NEXT, 1});
    endfunction

    task automatic step(input bit st, input bit rs);
        bit         e_l0w, e_l0r, e_ifw, e_ifr, e_ofr;
        bit         e_acc, e_rel, e_pw, e_busy, e_done, adv;
        logic [1:0] e_inst;
        kind_e      k;
        @(posedge clk);
        #1;
        start       = st;
        reset       = rs;
        l0_full     = stall_en && ($urandom_range(3) == 0);
        ififo_full  = stall_en && ($urandom_range(3) == 0);
        ofifo_valid = !stall_en || ($urandom_range(3) != 0);
        @(negedge clk);
        {e_l0w, e_l0r, e_ifw, e_ifr, e_ofr} = '0;
        {e_acc, e_rel, e_pw, e_busy, e_done, adv} = '0;
        e_inst = 2'b00;
        k = K_NEXT;
        if (m_act) begin
            e_busy = 1'b1;
            k = q[0].k;
            case (k)
                K_LDL0: begin e_l0w = !l0_full; adv = e_l0w; end
                K_LDFF: begin e_ifw = !ififo_full; adv = e_ifw; end
                K_FEED: begin e_inst = 2'b01; e_l0r = 1'b1; adv = 1'b1; end
                K_EXW:  begin e_inst = 2'b10; e_l0r = 1'b1; adv = 1'b1; end
                K_EXO: begin
                    e_inst = 2'b10; e_l0r = 1'b1; e_ifr = 1'b1; adv = 1'b1;
                end
                K_WB: begin
                    e_ofr = ofifo_valid;
                    e_pw  = ofifo_valid;
                    e_acc = (m_tile != 0);
                    e_rel = m_relu && (m_tile == m_last);
                    adv   = ofifo_valid;
                end
                K_NEXT: adv = 1'b1;
                K_DONE: begin e_done = 1'b1; adv = 1'b1; end
                default: adv = 1'b1;
            endcase
        end
        check("ctl",
              {20'd0, l0_wr, l0_rd, ififo_wr, ififo_rd, ofifo_rd, inst_w,
               sfp_acc_en, sfp_relu_en, psum_wr, busy, done},
              {20'd0, e_l0w, e_l0r, e_ifw, e_ifr, e_ofr, e_inst,
               e_acc, e_rel, e_pw, e_busy, e_done});
        check("sram_addr", 32'(sram_addr), 32'(m_sram));
        check("psum_addr", 32'(psum_addr), 32'(m_psum));
        check("tile_idx", 32'(tile_idx), 32'(m_tile));
        if (rs) begin
            m_act = 1'b0;
            q.delete();
            m_sram = '0;
            m_psum = '0;
            m_tile = '0;
        end else if (!m_act) begin
            if (st) begin
                m_act  = 1'b1;
                m_sram = in_base;
                m_psum = out_base;
                m_tile = '0;
                m_mode = mode;
                m_relu = relu;
                m_last = (num_tiles == 0) ? '0 : num_tiles - 1'b1;
                push_tile();
            end
        end else if (adv) begin
            if (k == K_LDL0 || k == K_LDFF) m_sram = m_sram + 1'b1;
            if (k == K_WB) m_psum = m_psum + 1'b1;
            q[0].n = q[0].n - 1;
            if (q[0].n == 0) begin
                void'(q.pop_front());
                if (k == K_NEXT) begin
                    if (m_tile == m_last) begin
                        q.push_back('{K_DONE, 1});
                    end else begin
                        m_tile = m_tile + 1'b1;
                        m_psum = out_base;
                        push_tile();
                    end
                end
                if (k == K_DONE) m_act = 1'b0;
            end
        end
    endtask

    task automatic run(input bit md, input bit rl, input logic [TW-1:0] nt,
                       input logic [AW-1:0] ib, input logic [AW-1:0] ob,
                       input bit se, input bit pulse, input int rst_at,
                       output int done_at);
        bit st;
        mode      = md;
        relu      = rl;
        num_tiles = nt;
        in_base   = ib;
        out_base  = ob;
        stall_en  = se;
        done_at   = -1;
        step(1'b1, 1'b0);
        for (int i = 1; i < 4000; i++) begin
            st = pulse && ($urandom_range(15) == 0);
            step(st, i == rst_at);
            if (done === 1'b1 && done_at < 0) done_at = i;
            if (!m_act) break;
            if (i == 3999) check("timeout", 32'(m_act), 32'd0);
        end
        stall_en = 1'b0;
        start    = 1'b0;
    endtask

    int d;

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        mode        = 1'b0;
        relu        = 1'b0;
        num_tiles   = '0;
        in_base     = '0;
        out_base    = '0;
        l0_full     = 1'b0;
        ififo_full  = 1'b0;
        ofifo_valid = 1'b1;
        stall_en    = 1'b0;
        m_act       = 1'b0;
        m_mode      = 1'b0;
        m_relu      = 1'b0;
        m_sram      = '0;
        m_psum      = '0;
        m_tile      = '0;
        m_last      = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);

        run(1'b0, 1'b0, 4'd1, 11'd0, 11'd100, 1'b0, 1'b0, 0, d);
        check("ws1_done_cycle", 32'(d), 32'd66);
        check("ws1_sram_end", 32'(sram_addr), 32'd16);

        run(1'b0, 1'b1, 4'd3, 11'd40, 11'd200, 1'b0, 1'b0, 0, d);
        check("ws3_sram_end", 32'(sram_addr), 32'd88);

        run(1'b1, 1'b0, 4'd1, 11'd5, 11'd300, 1'b0, 1'b0, 0, d);
        check("os1_done_cycle", 32'(d), 32'd50);

        run(1'b0, 1'b0, 4'd1, 11'd0, 11'd0, 1'b0, 1'b0, 40, d);
        check("rst_exec_no_done", 32'(d), 32'hffff_ffff);
        step(1'b0, 1'b0);
        run(1'b0, 1'b0, 4'd1, 11'd0, 11'd100, 1'b0, 1'b0, 0, d);
        check("after_rst_done_cycle", 32'(d), 32'd66);

        run(1'b0, 1'b0, 4'd0, 11'd7, 11'd9, 1'b0, 1'b1, 0, d);
        check("nt0_done_cycle", 32'(d), 32'd66);

        run(1'b0, 1'b0, 4'd1, 11'd2044, 11'd2046, 1'b0, 1'b0, 0, d);
        check("wrap_sram_end", 32'(sram_addr), 32'd12);

        for (int r = 0; r < 24; r++) begin
            run(1'($urandom_range(1)), 1'($urandom_range(1)),
                TW'($urandom_range(4)), AW'($urandom), AW'($urandom),
                1'b1, 1'b1,
                ($urandom_range(5) == 0) ? int'($urandom_range(200, 10)) : 0, d);
            step(1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
